// File: rtl/scr1_trace_checker.sv
// scr1_trace_checker: buffers core retirement events and checks them against a golden expected-record stream
module scr1_trace_checker #(
  parameter int FIFO_DEPTH  = 4,
  parameter int STOP_ON_ERR = 1,
  parameter int XLEN        = 32,
  parameter int AW          = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            clr,
  input  logic            update_pc_en,
  input  logic [XLEN-1:0] update_pc,
  input  logic            mprf_wr_en,
  input  logic [AW-1:0]   mprf_wr_addr,
  input  logic [XLEN-1:0] mprf_wr_data,
  input  logic            exp_vld,
  output logic            exp_rdy,
  input  logic [XLEN-1:0] exp_pc,
  input  logic            exp_wr_en,
  input  logic [AW-1:0]   exp_wr_addr,
  input  logic [XLEN-1:0] exp_wr_data,
  output logic            chk_err,
  output logic            chk_ovf,
  output logic [31:0]     chk_match_cnt,
  output logic [XLEN-1:0] err_pc,
  output logic [2:0]      err_field,
  output logic [1:0]      chk_state
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10} state_t;
  state_t state, state_nxt;
  logic [XLEN-1:0] f_pc [FIFO_DEPTH];
  logic [XLEN-1:0] f_data [FIFO_DEPTH];
  logic [AW-1:0] f_addr [FIFO_DEPTH];
  logic f_wen [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic run, ev, wen, full, pop, try_push, push, ovf, mis_pc, mis_wr, mis_data, mis, flush;
  assign run = state == RUN;
  assign ev = update_pc_en | mprf_wr_en;
  assign wen = mprf_wr_en & (mprf_wr_addr != '0);
  assign full = cnt == (PW+1)'(FIFO_DEPTH);
  assign exp_rdy = run & (cnt != '0);
  assign pop = exp_vld & exp_rdy;
  assign try_push = run & enable & ev;
  assign push = try_push & (~full | pop);
  assign ovf = try_push & full & ~pop;
  assign mis_pc = f_pc[rp] != exp_pc;
  assign mis_wr = (f_wen[rp] != exp_wr_en) | (f_wen[rp] & exp_wr_en & (f_addr[rp] != exp_wr_addr));
  assign mis_data = f_wen[rp] & exp_wr_en & (f_data[rp] != exp_wr_data);
  assign mis = pop & (mis_pc | mis_wr | mis_data);
  assign chk_state = state;
  always_comb begin
    state_nxt = state == IDLE ? (enable ? RUN : IDLE)
              : state == RUN  ? ((ovf | (mis & (STOP_ON_ERR != 0))) ? HALT : (enable ? RUN : IDLE))
              : HALT;
  end
  assign flush = run & (state_nxt == IDLE);
  always_ff @(posedge clk) begin
    if (push) begin
      f_pc[wp] <= update_pc;
      f_wen[wp] <= wen;
      f_addr[wp] <= wen ? mprf_wr_addr : '0;
      f_data[wp] <= wen ? mprf_wr_data : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      chk_err <= 1'b0;
      chk_ovf <= 1'b0;
      chk_match_cnt <= '0;
      err_pc <= '0;
      err_field <= '0;
    end else if (clr) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      chk_err <= 1'b0;
      chk_ovf <= 1'b0;
      chk_match_cnt <= '0;
      err_pc <= '0;
      err_field <= '0;
    end else begin
      state <= state_nxt;
      wp <= flush ? '0 : wp + PW'(push);
      rp <= flush ? '0 : rp + PW'(pop);
      cnt <= flush ? '0 : cnt + (PW+1)'(push) - (PW+1)'(pop);
      if (ovf) chk_ovf <= 1'b1;
      if (pop & ~mis) chk_match_cnt <= chk_match_cnt + 32'(~&chk_match_cnt);
      if (mis) chk_err <= 1'b1;
      if (mis & ~chk_err) begin
        err_pc <= f_pc[rp];
        err_field <= {mis_data, mis_wr, mis_pc};
      end
    end
  end
endmodule
